// File: rtl/spi_define.sv
// -----------------------------------------------------------------------------
// spi_define
// Shared definitions for the SPI flash read sequencer: the sequencer state
// encoding, the transfer-size (DTB) codes understood by the SPI core, the
// fill patterns shifted out while the flash is not listening, and the width
// of the chip-select setup/hold timer.
// -----------------------------------------------------------------------------
package spi_define;

   typedef enum logic [2:0] {
      IDLE,
      CSS,
      CMD,
      DUMMY,
      DATA,
      CSH,
      DONE
   } spi_seq_state_e;

   // Transfer size codes: 00 = one byte, 11 = four bytes
   localparam logic [1:0] SPI_DTB_8  = 2'b00;
   localparam logic [1:0] SPI_DTB_32 = 2'b11;

   // Patterns driven on MOSI during dummy bytes and data-phase words
   localparam logic [31:0] SPI_DUMMY_FILL = 32'h0000_00FF;
   localparam logic [31:0] SPI_DATA_FILL  = 32'hFFFF_FFFF;

   // Width of the CS setup/hold counter
   localparam int SPI_CS_TIMER_W = 8;

endpackage

// File: rtl/spi_seq_cstimer.sv
// -----------------------------------------------------------------------------
// spi_seq_cstimer
// Loadable down-counter that times the chip-select setup and hold windows.
// Loading value N makes done_o rise on the N-th enabled cycle after the load,
// so the owning state lasts exactly N cycles when it leaves on done_o.
//
// Ports:
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset
//   load_i      load load_val_i (takes priority over counting)
//   load_val_i  cycle count to time, must be >= 1
//   en_i        count down this cycle
//   done_o      the current cycle is the last one of the window
// -----------------------------------------------------------------------------
module spi_seq_cstimer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;

   // Stops at zero so an idle timer never wraps into a spurious done
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/spi_flash_seq.sv
// -----------------------------------------------------------------------------
// spi_flash_seq
// Flash read-command sequencer in front of the SPI transfer engine. Accepts
// one read request, holds CS low and issues: command + 24-bit address (one
// 4-byte word), N dummy bytes, then M 4-byte data words. Data-phase RX words
// pass straight through to the requester, whose ready throttles the core.
// Only one transfer is ever outstanding: the next TX word waits for the RX
// word of the previous one.
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   req_*                      read request (valid/ready, cmd, addr, dummy, len)
//   abort_i                    terminate the current frame
//   rd_valid_o/rd_ready_i      read data handshake, rd_data_o
//   done_o, err_o              end-of-frame pulse, err_o marks an aborted frame
//   tx_valid_o/tx_ready_i      TX word to the core, tx_data_o, dtb_o size code
//   rx_valid_i/rx_ready_o      RX word from the core, rx_data_i
//   nss_o                      chip-select, active low
// -----------------------------------------------------------------------------
module spi_flash_seq
   import spi_define::*;
#(
   parameter int LEN_WIDTH = 16,
   parameter int CSS_CYC   = 2,
   parameter int CSH_CYC   = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [7:0]           req_cmd_i,
   input  logic [23:0]          req_addr_i,
   input  logic [3:0]           req_dummy_i,
   input  logic [LEN_WIDTH-1:0] req_len_i,
   input  logic                 abort_i,
   output logic                 rd_valid_o,
   input  logic                 rd_ready_i,
   output logic [31:0]          rd_data_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic [31:0]          tx_data_o,
   output logic [1:0]           dtb_o,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   input  logic [31:0]          rx_data_i,
   output logic                 nss_o
);

   localparam int TW = SPI_CS_TIMER_W;

   spi_seq_state_e         state_q, state_d;
   logic [7:0]             cmd_q;
   logic [23:0]            addr_q;
   logic [3:0]             dummy_cnt_q;
   logic [LEN_WIDTH-1:0]   word_cnt_q;
   logic                   in_flight_q, in_flight_d;
   logic                   abort_q, abort_d;
   logic                   err_q;
   logic                   tx_hs, rx_hs, active, abort_now;
   logic                   timer_load, timer_done;
   logic [TW-1:0]          timer_val;

   spi_seq_cstimer #(.WIDTH(TW)) u_cstimer (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .en_i       ((state_q == CSS) || (state_q == CSH)),
      .done_o     (timer_done)
   );

   // Output decode and next-state logic. While an abort is being wound down
   // no new TX word is offered and the outstanding RX word, if any, is
   // swallowed regardless of the requester's ready. Once the abort has been
   // seen and nothing is outstanding the frame goes straight to CS hold.
   always_comb begin
      req_ready_o = 1'b0;
      nss_o       = 1'b1;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      dtb_o       = SPI_DTB_8;
      rx_ready_o  = 1'b0;
      rd_valid_o  = 1'b0;
      rd_data_o   = '0;
      done_o      = 1'b0;
      err_o       = 1'b0;

      case (state_q)
         IDLE: req_ready_o = 1'b1;
         CSS:  nss_o = 1'b0;
         CMD: begin
            nss_o      = 1'b0;
            tx_data_o  = {cmd_q, addr_q};
            dtb_o      = SPI_DTB_32;
            tx_valid_o = !in_flight_q && !abort_q;
            rx_ready_o = in_flight_q;
         end
         DUMMY: begin
            nss_o      = 1'b0;
            tx_data_o  = SPI_DUMMY_FILL;
            dtb_o      = SPI_DTB_8;
            tx_valid_o = !in_flight_q && !abort_q;
            rx_ready_o = in_flight_q;
         end
         DATA: begin
            nss_o      = 1'b0;
            tx_data_o  = SPI_DATA_FILL;
            dtb_o      = SPI_DTB_32;
            tx_valid_o = !in_flight_q && !abort_q;
            rx_ready_o = in_flight_q && (abort_q || rd_ready_i);
            rd_valid_o = in_flight_q && !abort_q && rx_valid_i;
            rd_data_o  = rx_data_i;
         end
         CSH:  nss_o = 1'b0;
         DONE: begin
            done_o = 1'b1;
            err_o  = err_q;
         end
         default: ;
      endcase

      tx_hs     = tx_valid_o && tx_ready_i;
      rx_hs     = rx_valid_i && rx_ready_o;
      active    = (state_q == CSS) || (state_q == CMD) ||
                  (state_q == DUMMY) || (state_q == DATA);
      abort_now = active && abort_i;

      in_flight_d = in_flight_q;
      if (tx_hs) in_flight_d = 1'b1;
      if (rx_hs) in_flight_d = 1'b0;

      state_d = state_q;
      case (state_q)
         IDLE:  if (req_valid_i) state_d = CSS;
         CSS:   if (timer_done) state_d = CMD;
         CMD: begin
            if (rx_hs) begin
               if (dummy_cnt_q != '0)     state_d = DUMMY;
               else if (word_cnt_q != '0) state_d = DATA;
               else                       state_d = CSH;
            end
         end
         DUMMY: begin
            if (rx_hs && (dummy_cnt_q == 4'd1)) begin
               state_d = (word_cnt_q != '0) ? DATA : CSH;
            end
         end
         DATA:  if (rx_hs && (word_cnt_q == LEN_WIDTH'(1))) state_d = CSH;
         CSH:   if (timer_done) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (active && (abort_q || abort_now)) begin
         state_d = in_flight_d ? state_q : CSH;
      end

      abort_d = (abort_q || abort_now) &&
                ((state_d == CSS) || (state_d == CMD) ||
                 (state_d == DUMMY) || (state_d == DATA));

      timer_load = ((state_d == CSS) && (state_q != CSS)) ||
                   ((state_d == CSH) && (state_q != CSH));
      timer_val  = (state_d == CSS) ? TW'(CSS_CYC) : TW'(CSH_CYC);
   end

   // State register plus the latched request and its phase counters
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         addr_q      <= '0;
         dummy_cnt_q <= '0;
         word_cnt_q  <= '0;
         in_flight_q <= 1'b0;
         abort_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_flight_q <= in_flight_d;
         abort_q     <= abort_d;
         if (state_q == IDLE) begin
            err_q <= 1'b0;
            if (req_valid_i) begin
               cmd_q       <= req_cmd_i;
               addr_q      <= req_addr_i;
               dummy_cnt_q <= req_dummy_i;
               word_cnt_q  <= req_len_i;
            end
         end else if (abort_now) begin
            err_q <= 1'b1;
         end
         if ((state_q == DUMMY) && rx_hs) dummy_cnt_q <= dummy_cnt_q - 4'd1;
         if ((state_q == DATA) && rx_hs)  word_cnt_q  <= word_cnt_q - LEN_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_spi_flash_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_seq
// Bench for the SPI flash read sequencer. A small SPI core model takes TX
// words with a random ready and answers each one with an RX word a fixed
// latency later, popping the answer from a response queue. Expected TX words
// and expected read words are queued when a request is set up and checked as
// the DUT produces them.
// -----------------------------------------------------------------------------
module tb_spi_flash_seq;
   import spi_define::*;

   localparam int CSS_CYC = 2;
   localparam int CSH_CYC = 2;
   localparam int RX_LAT  = 2;
   localparam int MAX_CYC = 3000;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [7:0]  req_cmd_i = '0;
   logic [23:0] req_addr_i = '0;
   logic [3:0]  req_dummy_i = '0;
   logic [15:0] req_len_i = '0;
   logic        abort_i = 1'b0;
   logic        rd_valid_o;
   logic        rd_ready_i = 1'b1;
   logic [31:0] rd_data_o;
   logic        done_o;
   logic        err_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b0;
   logic [31:0] tx_data_o;
   logic [1:0]  dtb_o;
   logic        rx_valid_i = 1'b0;
   logic        rx_ready_o;
   logic [31:0] rx_data_i = '0;
   logic        nss_o;

   spi_flash_seq #(.LEN_WIDTH(16), .CSS_CYC(CSS_CYC), .CSH_CYC(CSH_CYC)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_cmd_i   (req_cmd_i),
      .req_addr_i  (req_addr_i),
      .req_dummy_i (req_dummy_i),
      .req_len_i   (req_len_i),
      .abort_i     (abort_i),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rd_ready_i),
      .rd_data_o   (rd_data_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .tx_valid_o  (tx_valid_o),
      .tx_ready_i  (tx_ready_i),
      .tx_data_o   (tx_data_o),
      .dtb_o       (dtb_o),
      .rx_valid_i  (rx_valid_i),
      .rx_ready_o  (rx_ready_o),
      .rx_data_i   (rx_data_i),
      .nss_o       (nss_o)
   );

   always #5 clk_i = ~clk_i;

   int n_compared   = 0;
   int n_mismatched = 0;
   int tx_hs_total  = 0;

   logic [33:0] exp_tx_q [$];
   logic [31:0] exp_rd_q [$];
   logic [31:0] rx_resp_q [$];

   bit tx_hs_s = 1'b0;
   bit rx_hs_s = 1'b0;
   bit model_busy = 1'b0;
   int lat_cnt = 0;

   int f_first_tx, f_last_rx, f_done_cyc, f_tx_cnt, f_rd_cnt, f_done_cnt;
   bit f_nss_bad, f_err, f_timeout, f_hold_bad, f_rdv_seen, f_idle_after;

   // Scoreboard: compares every TX and read handshake against the queues
   always @(negedge clk_i) begin
      logic [33:0] exp_tx;
      logic [31:0] exp_rd;
      tx_hs_s = 1'b0;
      rx_hs_s = 1'b0;
      if (rst_n_i) begin
         tx_hs_s = tx_valid_o && tx_ready_i;
         rx_hs_s = rx_valid_i && rx_ready_o;
         if (tx_hs_s) begin
            tx_hs_total++;
            n_compared++;
            if (exp_tx_q.size() == 0) begin
               $display("[TB] FAIL tx_unexpected: got dtb=%b data=%h, required no transfer", dtb_o, tx_data_o);
               n_mismatched++;
            end else begin
               exp_tx = exp_tx_q.pop_front();
               if ({dtb_o, tx_data_o} !== exp_tx) begin
                  $display("[TB] FAIL tx_word: got dtb=%b data=%h, required dtb=%b data=%h",
                           dtb_o, tx_data_o, exp_tx[33:32], exp_tx[31:0]);
                  n_mismatched++;
               end
            end
            n_compared++;
            if (model_busy || nss_o) begin
               $display("[TB] FAIL tx_while_busy: got busy=%0b nss=%0b, required 0 0", model_busy, nss_o);
               n_mismatched++;
            end
         end
         if (rd_valid_o && rd_ready_i) begin
            n_compared++;
            if (exp_rd_q.size() == 0) begin
               $display("[TB] FAIL rd_unexpected: got %h, required no word", rd_data_o);
               n_mismatched++;
            end else begin
               exp_rd = exp_rd_q.pop_front();
               if (rd_data_o !== exp_rd) begin
                  $display("[TB] FAIL rd_word: got %h, required %h", rd_data_o, exp_rd);
                  n_mismatched++;
               end
            end
         end
      end
   end

   // SPI core model: one RX word per TX word, RX_LAT cycles later
   always @(posedge clk_i) begin
      #1;
      if (!rst_n_i) begin
         model_busy = 1'b0;
         rx_valid_i = 1'b0;
         rx_data_i  = '0;
         lat_cnt    = 0;
      end else begin
         if (rx_hs_s) begin
            rx_valid_i = 1'b0;
            rx_data_i  = '0;
            model_busy = 1'b0;
         end
         if (tx_hs_s) begin
            model_busy = 1'b1;
            lat_cnt    = RX_LAT;
         end else if (model_busy && !rx_valid_i) begin
            if (lat_cnt > 0) lat_cnt--;
            if (lat_cnt == 0) begin
               rx_valid_i = 1'b1;
               rx_data_i  = (rx_resp_q.size() != 0) ? rx_resp_q.pop_front() : 32'hBAD0_BAD0;
            end
         end
      end
      tx_ready_i = ($urandom_range(0, 3) != 0);
   end

   // Queues the expected traffic of a complete frame with random data words
   task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                                input logic [3:0] dummy, input logic [15:0] len);
      logic [31:0] d;
      exp_tx_q.push_back({SPI_DTB_32, cmd, addr});
      rx_resp_q.push_back(32'hC0DE_0000);
      for (int i = 0; i < int'(dummy); i++) begin
         exp_tx_q.push_back({SPI_DTB_8, 32'h0000_00FF});
         rx_resp_q.push_back(32'hC0DE_0100 + i);
      end
      for (int i = 0; i < int'(len); i++) begin
         d = $urandom;
         exp_tx_q.push_back({SPI_DTB_32, 32'hFFFF_FFFF});
         rx_resp_q.push_back(d);
         exp_rd_q.push_back(d);
      end
   endtask

   // Issues one request and watches the frame until done_o. Optionally
   // pulses abort after TX handshake number abort_tx, and stalls the reader
   // for hold_cyc cycles once word hold_word is presented.
   task automatic drive_frame(input logic [7:0] cmd, input logic [23:0] addr,
                              input logic [3:0] dummy, input logic [15:0] len,
                              input int abort_tx, input int hold_word, input int hold_cyc);
      int cyc, abort_ph, hold_st, hold_left;
      bit accepted, finished;
      f_first_tx = -1; f_last_rx = -1; f_done_cyc = -1;
      f_tx_cnt = 0; f_rd_cnt = 0; f_done_cnt = 0;
      f_nss_bad = 0; f_err = 0; f_timeout = 0; f_hold_bad = 0; f_rdv_seen = 0; f_idle_after = 0;
      abort_ph = 0; hold_st = 0; hold_left = 0;
      @(posedge clk_i); #1;
      req_cmd_i = cmd; req_addr_i = addr; req_dummy_i = dummy; req_len_i = len;
      req_valid_i = 1'b1;
      accepted = 0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            accepted = 1;
            if (!nss_o) f_nss_bad = 1;
         end
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      if (!accepted) begin
         f_timeout = 1;
         return;
      end
      cyc = 0; finished = 0;
      while (!finished && cyc < MAX_CYC) begin
         if (cyc > 0) begin
            @(posedge clk_i); #1;
         end
         if (abort_ph == 1) begin abort_i = 1'b1; abort_ph = 2; end
         else if (abort_ph == 2) begin abort_i = 1'b0; abort_ph = 3; end
         if (hold_st == 1) begin rd_ready_i = 1'b0; hold_st = 2; end
         else if (hold_st == 4) begin rd_ready_i = 1'b1; hold_st = 5; end
         @(negedge clk_i);
         cyc++;
         if (f_first_tx < 0 && tx_valid_o) f_first_tx = cyc;
         if (tx_valid_o && tx_ready_i) begin
            f_tx_cnt++;
            if (f_tx_cnt == abort_tx && abort_ph == 0) abort_ph = 1;
         end
         if (rx_valid_i && rx_ready_o) f_last_rx = cyc;
         if (rd_valid_o) f_rdv_seen = 1;
         if (rd_valid_o && rd_ready_i) begin
            f_rd_cnt++;
            if (hold_word > 0 && f_rd_cnt == hold_word - 1 && hold_st == 0) hold_st = 1;
         end
         if (hold_st == 2 && rd_valid_o) begin hold_st = 3; hold_left = hold_cyc; end
         if (hold_st == 3) begin
            if (rx_ready_o || tx_valid_o || !rd_valid_o) f_hold_bad = 1;
            hold_left--;
            if (hold_left == 0) hold_st = 4;
         end
         if (done_o) begin
            f_done_cnt++; f_err = err_o; f_done_cyc = cyc; finished = 1;
            if (!nss_o) f_nss_bad = 1;
         end else if (nss_o) begin
            f_nss_bad = 1;
         end
      end
      abort_i = 1'b0;
      rd_ready_i = 1'b1;
      if (!finished) begin
         f_timeout = 1;
         return;
      end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      if (done_o) f_done_cnt++;
      f_idle_after = req_ready_o && nss_o;
   endtask

   task automatic test_reset;
      logic [72:0] got, req;
      rst_n_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      got = {req_ready_o, nss_o, tx_valid_o, rx_ready_o, rd_valid_o, done_o, err_o, dtb_o, tx_data_o, rd_data_o};
      req = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
      n_compared++;
      if (got !== req) begin
         $display("[TB] FAIL reset_values: got %h, required %h", got, req);
         n_mismatched++;
      end
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
   endtask

   task automatic test_basic_read(input string tag);
      exp_tx_q.push_back({SPI_DTB_32, 32'h0312_3456});
      exp_tx_q.push_back({SPI_DTB_32, 32'hFFFF_FFFF});
      exp_tx_q.push_back({SPI_DTB_32, 32'hFFFF_FFFF});
      rx_resp_q.push_back(32'hC0DE_0000);
      rx_resp_q.push_back(32'hDEAD_BEEF);
      rx_resp_q.push_back(32'h0102_0304);
      exp_rd_q.push_back(32'hDEAD_BEEF);
      exp_rd_q.push_back(32'h0102_0304);
      drive_frame(8'h03, 24'h123456, 4'd0, 16'd2, 0, 0, 0);
      n_compared++;
      if (f_timeout) begin $display("[TB] FAIL %s_timeout: got no done_o, required done_o", tag); n_mismatched++; end
      n_compared++;
      if (f_first_tx != CSS_CYC + 1) begin
         $display("[TB] FAIL %s_css_len: got first tx at cycle %0d, required %0d", tag, f_first_tx, CSS_CYC + 1);
         n_mismatched++;
      end
      n_compared++;
      if (f_done_cyc - f_last_rx != CSH_CYC + 1) begin
         $display("[TB] FAIL %s_csh_len: got %0d, required %0d", tag, f_done_cyc - f_last_rx, CSH_CYC + 1);
         n_mismatched++;
      end
      n_compared++;
      if ({f_tx_cnt, f_rd_cnt, f_done_cnt} !== {32'd3, 32'd2, 32'd1}) begin
         $display("[TB] FAIL %s_counts: got tx=%0d rd=%0d done=%0d, required 3 2 1", tag, f_tx_cnt, f_rd_cnt, f_done_cnt);
         n_mismatched++;
      end
      n_compared++;
      if (f_nss_bad || f_err || !f_idle_after) begin
         $display("[TB] FAIL %s_frame: got nss_bad=%0b err=%0b idle=%0b, required 0 0 1", tag, f_nss_bad, f_err, f_idle_after);
         n_mismatched++;
      end
      n_compared++;
      if (exp_tx_q.size() + exp_rd_q.size() != 0) begin
         $display("[TB] FAIL %s_leftover: got %0d tx %0d rd pending, required 0 0", tag, exp_tx_q.size(), exp_rd_q.size());
         n_mismatched++;
      end
   endtask

   task automatic test_dummy_read;
      applyStimulus(8'h0B, 24'hABCDEF, 4'd3, 16'd1);
      drive_frame(8'h0B, 24'hABCDEF, 4'd3, 16'd1, 0, 0, 0);
      n_compared++;
      if ({f_timeout, f_tx_cnt, f_rd_cnt, f_done_cnt, f_err} !== {1'b0, 32'd5, 32'd1, 32'd1, 1'b0}) begin
         $display("[TB] FAIL dummy_frame: got to=%0b tx=%0d rd=%0d done=%0d err=%0b, required 0 5 1 1 0",
                  f_timeout, f_tx_cnt, f_rd_cnt, f_done_cnt, f_err);
         n_mismatched++;
      end
      n_compared++;
      if (exp_tx_q.size() + exp_rd_q.size() != 0 || f_nss_bad) begin
         $display("[TB] FAIL dummy_leftover: got %0d pending nss_bad=%0b, required 0 0",
                  exp_tx_q.size() + exp_rd_q.size(), f_nss_bad);
         n_mismatched++;
      end
   endtask

   task automatic test_cmd_only;
      applyStimulus(8'h06, 24'h000000, 4'd0, 16'd0);
      drive_frame(8'h06, 24'h000000, 4'd0, 16'd0, 0, 0, 0);
      n_compared++;
      if ({f_timeout, f_tx_cnt, f_rdv_seen, f_done_cnt, f_err} !== {1'b0, 32'd1, 1'b0, 32'd1, 1'b0}) begin
         $display("[TB] FAIL cmd_only: got to=%0b tx=%0d rdv=%0b done=%0d err=%0b, required 0 1 0 1 0",
                  f_timeout, f_tx_cnt, f_rdv_seen, f_done_cnt, f_err);
         n_mismatched++;
      end
      n_compared++;
      if (f_done_cyc - f_last_rx != CSH_CYC + 1 || exp_tx_q.size() != 0) begin
         $display("[TB] FAIL cmd_only_csh: got gap=%0d pending=%0d, required %0d 0",
                  f_done_cyc - f_last_rx, exp_tx_q.size(), CSH_CYC + 1);
         n_mismatched++;
      end
   endtask

   task automatic test_backpressure;
      applyStimulus(8'h03, 24'h000040, 4'd0, 16'd4);
      drive_frame(8'h03, 24'h000040, 4'd0, 16'd4, 0, 2, 10);
      n_compared++;
      if (f_hold_bad) begin
         $display("[TB] FAIL stall_hold: got rx_ready/tx_valid activity during stall, required none");
         n_mismatched++;
      end
      n_compared++;
      if ({f_timeout, f_tx_cnt, f_rd_cnt, f_done_cnt} !== {1'b0, 32'd5, 32'd4, 32'd1} || exp_rd_q.size() != 0) begin
         $display("[TB] FAIL stall_counts: got to=%0b tx=%0d rd=%0d done=%0d, required 0 5 4 1",
                  f_timeout, f_tx_cnt, f_rd_cnt, f_done_cnt);
         n_mismatched++;
      end
   endtask

   task automatic test_abort;
      logic [31:0] d1, d2;
      d1 = $urandom; d2 = $urandom;
      exp_tx_q.push_back({SPI_DTB_32, 32'h0300_0100});
      exp_tx_q.push_back({SPI_DTB_32, 32'hFFFF_FFFF});
      exp_tx_q.push_back({SPI_DTB_32, 32'hFFFF_FFFF});
      rx_resp_q.push_back(32'hC0DE_0000);
      rx_resp_q.push_back(d1);
      rx_resp_q.push_back(d2);
      exp_rd_q.push_back(d1);
      drive_frame(8'h03, 24'h000100, 4'd0, 16'd4, 3, 0, 0);
      n_compared++;
      if ({f_timeout, f_tx_cnt, f_rd_cnt, f_done_cnt, f_err} !== {1'b0, 32'd3, 32'd1, 32'd1, 1'b1}) begin
         $display("[TB] FAIL abort_frame: got to=%0b tx=%0d rd=%0d done=%0d err=%0b, required 0 3 1 1 1",
                  f_timeout, f_tx_cnt, f_rd_cnt, f_done_cnt, f_err);
         n_mismatched++;
      end
      n_compared++;
      if (rx_resp_q.size() != 0 || exp_tx_q.size() != 0 || f_done_cyc - f_last_rx != CSH_CYC + 1) begin
         $display("[TB] FAIL abort_drain: got rx_left=%0d tx_left=%0d gap=%0d, required 0 0 %0d",
                  rx_resp_q.size(), exp_tx_q.size(), f_done_cyc - f_last_rx, CSH_CYC + 1);
         n_mismatched++;
      end
      test_basic_read("after_abort");
   endtask

   task automatic test_reset_mid_frame;
      int start;
      bit reached;
      applyStimulus(8'h0B, 24'h000200, 4'd3, 16'd1);
      start = tx_hs_total;
      @(posedge clk_i); #1;
      req_cmd_i = 8'h0B; req_addr_i = 24'h000200; req_dummy_i = 4'd3; req_len_i = 16'd1;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         @(negedge clk_i);
         if (tx_hs_total - start >= 2) reached = 1;
      end
      n_compared++;
      if (!reached) begin
         $display("[TB] FAIL reset_reach_dummy: got %0d tx, required 2", tx_hs_total - start);
         n_mismatched++;
      end
      @(posedge clk_i); #2;
      rst_n_i = 1'b0;
      #1;
      n_compared++;
      if ({nss_o, tx_valid_o, req_ready_o, rd_valid_o, done_o} !== 5'b10100) begin
         $display("[TB] FAIL reset_async: got nss/txv/rdy/rdv/done=%b, required 10100",
                  {nss_o, tx_valid_o, req_ready_o, rd_valid_o, done_o});
         n_mismatched++;
      end
      exp_tx_q.delete(); exp_rd_q.delete(); rx_resp_q.delete();
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      n_compared++;
      if (req_ready_o !== 1'b1) begin
         $display("[TB] FAIL reset_release: got req_ready=%b, required 1", req_ready_o);
         n_mismatched++;
      end
      test_basic_read("after_reset");
   endtask

   // Final tally line
   task automatic checkOutput;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_basic_read("basic");
      test_dummy_read();
      test_cmd_only();
      test_backpressure();
      test_abort();
      test_reset_mid_frame();
      repeat (2) @(posedge clk_i);
      checkOutput();
      $finish;
   end

endmodule
